rvh_l1d_amo_ctrl: RTL and testbench
===================================

Name: rvh_l1d_amo_ctrl

Overview:
Sequencer that executes one RISC-V AMO (RV64A) at a time inside the L1D. It accepts an AMO from the LSU, reads the 64-bit data word, and drives the combinational rvh_l1d_alu issue interface to compute the new value. It then writes the new value back with a byte mask and returns the old value to the LSU. It is the issuing and consuming side of rvh_l1d_alu's issue/write-back interface and adds the handshakes and state that the ALU lacks.

Parameters:
XLEN, 64, data word width; fixed at 64 (RV64).
TAG_W, 6, width of the requester tag carried from request to response.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid_i  in  1  AMO request valid
req_ready_o  out  1  high only in IDLE
req_op_i  in  4  amo_op_e: SWAP, ADD, AND, OR, XOR, MIN, MAX, MINU, MAXU
req_w_i  in  1  1 = .W, 0 = .D
req_off_i  in  3  byte offset of the address within the 64-bit word
req_rs2_i  in  XLEN  source operand
req_tag_i  in  TAG_W  requester tag
rd_req_valid_o  out  1  data-word read request
rd_req_ready_i  in  1  read request accepted
rd_resp_valid_i  in  1  read data valid, single-cycle pulse
rd_resp_data_i  in  XLEN  read data
wr_valid_o  out  1  write-back valid
wr_ready_i  in  1  write-back accepted
wr_data_o  out  XLEN  write data, positioned within the word
wr_mask_o  out  8  byte enable
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response accepted
resp_data_o  out  XLEN  old memory value; .W is sign-extended
resp_tag_o  out  TAG_W  tag of the request
resp_err_o  out  1  misaligned request; memory is not written

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state = IDLE; rd_req_valid_o, wr_valid_o, resp_valid_o and resp_err_o = 0; wr_mask_o = 0; all data and tag registers = 0.
- A reset asserted mid-operation drops the in-flight AMO. No write is issued after reset. A rd_resp arriving after reset is ignored.
- FSM states and transitions:
  - IDLE: on req_valid_i, capture op, w, off, rs2 and tag.
    - Misaligned (.D with off != 0, or .W with off[1:0] != 0): go to RESP with err = 1 and resp_data = 0.
    - Otherwise go to RD.
  - RD: rd_req_valid_o = 1, held until rd_req_ready_i, then go to RD_WAIT.
  - RD_WAIT: wait for rd_resp_valid_i; capture old value, then go to CALC. rd_resp_valid_i is sampled only in this state.
  - CALC: one cycle; register new value, wr_data and wr_mask, then go to WR.
  - WR: wr_valid_o = 1, held until wr_ready_i, then go to RESP.
  - RESP: resp_valid_o = 1, held until resp_ready_i, then go to IDLE.
- Output stability: wr_* and resp_* are registered and stay stable while valid is high and ready is low.
- Latency: with all readies high and rd_resp arriving one cycle after the read request, request accepted at T0, rd_req T1, rd_resp T2, CALC T3, wr T4, resp T5. The earliest next request is accepted at T6.
- Word select: for .W, half = off[2] (0 selects bits [31:0]); the .W old value is sign-extended from that half.
- Operand forming for ALU issue_operand0_i/issue_operand1_i:
  - .D: operand0 = old, operand1 = rs2.
  - .W, signed ops: both operands are sign-extended from bit 31. The old-value half is selected by off[2]; rs2 always uses rs2[31:0].
  - .W, MINU/MAXU: both operands are zero-extended from bit 31 so the 64-bit SLTU compares correctly.
- ALU issue mapping:
  - ADD: ALU_ADD with issue_op_w_i = req_w.
  - AND/OR/XOR: ALU_AND/OR/XOR with issue_op_w_i = 0.
  - MIN/MAX: ALU_SLT.
  - MINU/MAXU: ALU_SLTU.
  - SWAP: no ALU use; new = rs2.
- Selection:
  - lt = ~wb_data_o[0] for SLT-type ops (rvh_l1d_alu returns the inverted compare).
  - MIN/MINU: new = lt ? old : rs2.
  - MAX/MAXU: new = lt ? rs2 : old.
  - Otherwise new = wb_data_o.
- Write placement:
  - .D: wr_data = new, mask = 0xFF.
  - .W: wr_data = {2{new[31:0]}}, mask = 0x0F if off[2] = 0, else 0xF0.
- Equal operands for MIN/MAX write the old value, so the value is unchanged.

Decomposition:
- rvh_l1d_pkg: amo_op_e enum (4 bits), and amo_state_e with IDLE, RD, RD_WAIT, CALC, WR, RESP.
- ALU_* opcodes come from uop_encoding_pkg.
- One sub-module: an instance of the existing combinational rvh_l1d_alu.
- Operand forming and selection are local combinational logic.

Test Plan:
- AMOADD.D, old = 0x0000_0000_0000_0005, rs2 = 0x3 -> wr_data = 0x8, mask = 0xFF, resp_data = 0x5; resp_valid at T5 with all readies high.
- AMOMAX.W, off = 4, old = 0x8000_0000_0000_0001, rs2 = 0x0000_0001 -> new = 0x0000_0001 (1 > -2^31); wr_data = 0x0000_0001_0000_0001, mask = 0xF0, resp_data = 0xFFFF_FFFF_8000_0000.
- AMOMINU.W, off = 0, old low half = 0xFFFF_FFFF, rs2 = 0x1 -> new low half = 0x1, mask = 0x0F, resp_data = 0xFFFF_FFFF_FFFF_FFFF.
- AMOSWAP.D with wr_ready_i low for 3 cycles and resp_ready_i low for 2 cycles -> wr_*/resp_* held stable; exactly one write and one response.
- Misaligned AMOOR.D, off = 4 -> no rd_req and no write; resp_err = 1, resp_data = 0; tag echoed.
- rst asserted in RD_WAIT, followed by a stray rd_resp_valid -> all outputs 0, no write; the next request completes normally.

Source files
------------

// File: rtl/rvh_l1d_pkg.sv
// L1D-local types for the AMO sequencer: AMO opcodes and sequencer states.
// Also holds the alignment rule shared by the RTL.
package rvh_l1d_pkg;

    typedef enum logic [3:0] {
        AMO_SWAP = 4'd0,
        AMO_ADD  = 4'd1,
        AMO_AND  = 4'd2,
        AMO_OR   = 4'd3,
        AMO_XOR  = 4'd4,
        AMO_MIN  = 4'd5,
        AMO_MAX  = 4'd6,
        AMO_MINU = 4'd7,
        AMO_MAXU = 4'd8
    } amo_op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_WAIT = 3'd2,
        CALC    = 3'd3,
        WR      = 3'd4,
        RESP    = 3'd5
    } amo_state_e;

    // .D must be 8-byte aligned, .W must be 4-byte aligned.
    function automatic logic amo_misaligned(input logic is_w, input logic [2:0] off);
        return is_w ? (off[1:0] != 2'b00) : (off != 3'b000);
    endfunction

endpackage

// File: rtl/uop_encoding_pkg.sv
// Micro-op encodings shared by the L1D execution helpers.
// The ALU opcode is a plain 4-bit code so other units can carry it on buses.
package uop_encoding_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 4'd0;
    localparam alu_op_t ALU_AND  = 4'd1;
    localparam alu_op_t ALU_OR   = 4'd2;
    localparam alu_op_t ALU_XOR  = 4'd3;
    localparam alu_op_t ALU_SLT  = 4'd4;
    localparam alu_op_t ALU_SLTU = 4'd5;

endpackage

// File: rtl/rvh_l1d_alu.sv
// Combinational L1D ALU. Compare ops return the inverted result in bit 0,
// so callers must use ~wb_data_o[0] as "operand0 < operand1".
module rvh_l1d_alu
    import uop_encoding_pkg::*;
#(
    parameter int XLEN = 64
)
(
    input  alu_op_t          issue_opcode_i,
    input  logic             issue_op_w_i,
    input  logic [XLEN-1:0]  issue_operand0_i,
    input  logic [XLEN-1:0]  issue_operand1_i,
    output logic [XLEN-1:0]  wb_data_o
);

    logic [XLEN-1:0] sum;

    always_comb begin
        sum       = issue_operand0_i + issue_operand1_i;
        wb_data_o = '0;
        case (issue_opcode_i)
            ALU_ADD:  wb_data_o = issue_op_w_i ? {{(XLEN-32){sum[31]}}, sum[31:0]} : sum;
            ALU_AND:  wb_data_o = issue_operand0_i & issue_operand1_i;
            ALU_OR:   wb_data_o = issue_operand0_i | issue_operand1_i;
            ALU_XOR:  wb_data_o = issue_operand0_i ^ issue_operand1_i;
            ALU_SLT:  wb_data_o[0] = ~($signed(issue_operand0_i) < $signed(issue_operand1_i));
            ALU_SLTU: wb_data_o[0] = ~(issue_operand0_i < issue_operand1_i);
            default:  wb_data_o = '0;
        endcase
    end

endmodule

// File: rtl/rvh_l1d_amo_ctrl.sv
// One-at-a-time RV64A AMO sequencer: read word, compute via rvh_l1d_alu,
// write back with byte mask, return the old value to the LSU.
module rvh_l1d_amo_ctrl
    import rvh_l1d_pkg::*;
    import uop_encoding_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 6
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        req_op_i,
    input  logic              req_w_i,
    input  logic [2:0]        req_off_i,
    input  logic [XLEN-1:0]   req_rs2_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    output logic              rd_req_valid_o,
    input  logic              rd_req_ready_i,
    input  logic              rd_resp_valid_i,
    input  logic [XLEN-1:0]   rd_resp_data_i,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic [XLEN-1:0]   wr_data_o,
    output logic [7:0]        wr_mask_o,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [XLEN-1:0]   resp_data_o,
    output logic [TAG_W-1:0]  resp_tag_o,
    output logic              resp_err_o
);

    amo_state_e        state_reg, state_next;
    amo_op_e           op_reg;
    logic              w_reg;
    logic              half_reg;
    logic [XLEN-1:0]   rs2_reg;
    logic [XLEN-1:0]   old_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic              err_reg;
    logic [XLEN-1:0]   wr_data_reg;
    logic [7:0]        wr_mask_reg;
    logic [XLEN-1:0]   resp_data_reg;

    // ---------------- FSM: next state and handshake outputs ----------------
    always_comb begin
        state_next     = state_reg;
        req_ready_o    = 1'b0;
        rd_req_valid_o = 1'b0;
        wr_valid_o     = 1'b0;
        resp_valid_o   = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i)
                    state_next = amo_misaligned(req_w_i, req_off_i) ? RESP : RD;
            end
            RD: begin
                rd_req_valid_o = 1'b1;
                if (rd_req_ready_i) state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (rd_resp_valid_i) state_next = CALC;
            end
            CALC: state_next = WR;
            WR: begin
                wr_valid_o = 1'b1;
                if (wr_ready_i) state_next = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- Operand forming and ALU issue ----------------
    logic [31:0]      rd_half, old_half;
    logic             cmp_unsigned;
    alu_op_t          alu_op;
    logic             alu_w;
    logic [XLEN-1:0]  op0, op1, alu_wb, new_val;
    logic             lt;
    logic [7:0]       w_mask;
    logic [XLEN-1:0]  wr_data_next;
    logic [7:0]       wr_mask_next;

    assign rd_half      = half_reg ? rd_resp_data_i[63:32] : rd_resp_data_i[31:0];
    assign old_half     = half_reg ? old_reg[63:32] : old_reg[31:0];
    assign cmp_unsigned = (op_reg == AMO_MINU) || (op_reg == AMO_MAXU);

    always_comb begin
        alu_op = ALU_ADD;
        alu_w  = 1'b0;
        case (op_reg)
            AMO_ADD:  begin alu_op = ALU_ADD; alu_w = w_reg; end
            AMO_AND:  alu_op = ALU_AND;
            AMO_OR:   alu_op = ALU_OR;
            AMO_XOR:  alu_op = ALU_XOR;
            AMO_MIN,
            AMO_MAX:  alu_op = ALU_SLT;
            AMO_MINU,
            AMO_MAXU: alu_op = ALU_SLTU;
            default:  alu_op = ALU_ADD;
        endcase

        // .W unsigned compares need zero extension so a 64-bit SLTU orders them correctly.
        if (!w_reg) begin
            op0 = old_reg;
            op1 = rs2_reg;
        end else if (cmp_unsigned) begin
            op0 = {{(XLEN-32){1'b0}}, old_half};
            op1 = {{(XLEN-32){1'b0}}, rs2_reg[31:0]};
        end else begin
            op0 = {{(XLEN-32){old_half[31]}}, old_half};
            op1 = {{(XLEN-32){rs2_reg[31]}}, rs2_reg[31:0]};
        end
    end

    rvh_l1d_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .issue_opcode_i   (alu_op),
        .issue_op_w_i     (alu_w),
        .issue_operand0_i (op0),
        .issue_operand1_i (op1),
        .wb_data_o        (alu_wb)
    );

    assign lt = ~alu_wb[0];

    // Equal operands keep the old value for both MIN and MAX.
    always_comb begin
        case (op_reg)
            AMO_SWAP:          new_val = rs2_reg;
            AMO_MIN, AMO_MINU: new_val = lt ? op0 : op1;
            AMO_MAX, AMO_MAXU: new_val = lt ? op1 : op0;
            default:           new_val = alu_wb;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_wmask
            if (gi >= 4) begin : g_hi
                assign w_mask[gi] = half_reg;
            end else begin : g_lo
                assign w_mask[gi] = ~half_reg;
            end
        end
    endgenerate

    assign wr_data_next = w_reg ? {2{new_val[31:0]}} : new_val;
    assign wr_mask_next = w_reg ? w_mask : 8'hFF;

    // ---------------- State and data registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            op_reg        <= AMO_SWAP;
            w_reg         <= 1'b0;
            half_reg      <= 1'b0;
            rs2_reg       <= '0;
            old_reg       <= '0;
            tag_reg       <= '0;
            err_reg       <= 1'b0;
            wr_data_reg   <= '0;
            wr_mask_reg   <= '0;
            resp_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && req_valid_i) begin
                op_reg        <= amo_op_e'(req_op_i);
                w_reg         <= req_w_i;
                half_reg      <= req_off_i[2];
                rs2_reg       <= req_rs2_i;
                tag_reg       <= req_tag_i;
                err_reg       <= amo_misaligned(req_w_i, req_off_i);
                resp_data_reg <= '0;
            end
            if (state_reg == RD_WAIT && rd_resp_valid_i) begin
                old_reg       <= rd_resp_data_i;
                resp_data_reg <= w_reg ? {{(XLEN-32){rd_half[31]}}, rd_half} : rd_resp_data_i;
            end
            if (state_reg == CALC) begin
                wr_data_reg <= wr_data_next;
                wr_mask_reg <= wr_mask_next;
            end
        end
    end

    assign wr_data_o   = wr_data_reg;
    assign wr_mask_o   = wr_mask_reg;
    assign resp_data_o = resp_data_reg;
    assign resp_tag_o  = tag_reg;
    assign resp_err_o  = err_reg;

endmodule

// File: tb/tb_rvh_l1d_amo_ctrl.sv
// Bench for rvh_l1d_amo_ctrl: directed vector table, handshake/reset sequences,
// and randomized AMOs checked against a plain-arithmetic reference model.
module tb_rvh_l1d_amo_ctrl;
    import rvh_l1d_pkg::*;

    localparam int XLEN  = 64;
    localparam int TAG_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [3:0]        req_op = '0;
    logic              req_w = 1'b0;
    logic [2:0]        req_off = '0;
    logic [XLEN-1:0]   req_rs2 = '0;
    logic [TAG_W-1:0]  req_tag = '0;
    logic              rd_req_valid;
    logic              rd_req_ready = 1'b0;
    logic              rd_resp_valid = 1'b0;
    logic [XLEN-1:0]   rd_resp_data = '0;
    logic              wr_valid;
    logic              wr_ready = 1'b0;
    logic [XLEN-1:0]   wr_data;
    logic [7:0]        wr_mask;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [XLEN-1:0]   resp_data;
    logic [TAG_W-1:0]  resp_tag;
    logic              resp_err;

    always #5 clk = ~clk;

    rvh_l1d_amo_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_op_i        (req_op),
        .req_w_i         (req_w),
        .req_off_i       (req_off),
        .req_rs2_i       (req_rs2),
        .req_tag_i       (req_tag),
        .rd_req_valid_o  (rd_req_valid),
        .rd_req_ready_i  (rd_req_ready),
        .rd_resp_valid_i (rd_resp_valid),
        .rd_resp_data_i  (rd_resp_data),
        .wr_valid_o      (wr_valid),
        .wr_ready_i      (wr_ready),
        .wr_data_o       (wr_data),
        .wr_mask_o       (wr_mask),
        .resp_valid_o    (resp_valid),
        .resp_ready_i    (resp_ready),
        .resp_data_o     (resp_data),
        .resp_tag_o      (resp_tag),
        .resp_err_o      (resp_err)
    );

    typedef struct {
        logic [3:0]  op;
        logic        w;
        logic [2:0]  off;
        logic [63:0] rs2;
        logic [63:0] old;
        logic [5:0]  tag;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_mask;
        logic [63:0] exp_resp;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [63:0] wdata;
        logic [7:0]  mask;
        logic [63:0] rdata;
        logic        err;
        logic [5:0]  tag;
        int          n_rd;
        int          n_wr;
        int          n_resp;
        int          lat;
        logic        wr_stable;
        logic        resp_stable;
        logic        done;
        logic        ready_after;
    } obs_t;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endfunction

    // Reference: AMO semantics from plain arithmetic on the selected word.
    function automatic void ref_amo(input logic [3:0] op, input logic w, input logic [2:0] off,
                                    input logic [63:0] rs2, input logic [63:0] old,
                                    output logic [63:0] wd, output logic [7:0] mk,
                                    output logic [63:0] rd, output logic err);
        logic [31:0] a32, b32, n32;
        logic [63:0] n64;
        wd = '0; mk = '0; rd = '0; err = 1'b0;
        if (w ? (off[1:0] != 2'b00) : (off != 3'b000)) begin
            err = 1'b1;
            return;
        end
        if (w) begin
            a32 = off[2] ? old[63:32] : old[31:0];
            b32 = rs2[31:0];
            case (op)
                AMO_SWAP: n32 = b32;
                AMO_ADD:  n32 = a32 + b32;
                AMO_AND:  n32 = a32 & b32;
                AMO_OR:   n32 = a32 | b32;
                AMO_XOR:  n32 = a32 ^ b32;
                AMO_MIN:  n32 = ($signed(a32) <= $signed(b32)) ? a32 : b32;
                AMO_MAX:  n32 = ($signed(a32) >= $signed(b32)) ? a32 : b32;
                AMO_MINU: n32 = (a32 <= b32) ? a32 : b32;
                AMO_MAXU: n32 = (a32 >= b32) ? a32 : b32;
                default:  n32 = '0;
            endcase
            wd = {n32, n32};
            mk = off[2] ? 8'hF0 : 8'h0F;
            rd = {{32{a32[31]}}, a32};
        end else begin
            case (op)
                AMO_SWAP: n64 = rs2;
                AMO_ADD:  n64 = old + rs2;
                AMO_AND:  n64 = old & rs2;
                AMO_OR:   n64 = old | rs2;
                AMO_XOR:  n64 = old ^ rs2;
                AMO_MIN:  n64 = ($signed(old) <= $signed(rs2)) ? old : rs2;
                AMO_MAX:  n64 = ($signed(old) >= $signed(rs2)) ? old : rs2;
                AMO_MINU: n64 = (old <= rs2) ? old : rs2;
                AMO_MAXU: n64 = (old >= rs2) ? old : rs2;
                default:  n64 = '0;
            endcase
            wd = n64;
            mk = 8'hFF;
            rd = old;
        end
    endfunction

    // Drives one AMO through all handshakes; memory returns 'old' one cycle after the read request.
    task automatic run_amo(input logic [3:0] op, input logic w, input logic [2:0] off,
                           input logic [63:0] rs2, input logic [63:0] old, input logic [5:0] tag,
                           input int wr_stall, input int resp_stall, output obs_t o);
        int  acc_cyc, wr_wait, resp_wait;
        bit  accepted, rd_fire;
        o.wdata = '0; o.mask = '0; o.rdata = '0; o.err = 1'b0; o.tag = '0;
        o.n_rd = 0; o.n_wr = 0; o.n_resp = 0; o.lat = -1;
        o.wr_stable = 1'b1; o.resp_stable = 1'b1; o.done = 1'b0; o.ready_after = 1'b0;
        accepted = 0; rd_fire = 0; acc_cyc = 0; wr_wait = 0; resp_wait = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_w = w; req_off = off; req_rs2 = rs2; req_tag = tag;
        rd_req_ready = 1'b1;
        for (int cyc = 0; cyc < 300 && !o.done; cyc++) begin
            if (accepted) req_valid = 1'b0;
            rd_resp_valid = rd_fire;
            rd_resp_data  = rd_fire ? old : 64'h0;
            rd_fire = 0;
            if (rd_req_valid) begin
                o.n_rd++;
                rd_fire = 1;
            end
            wr_ready = 1'b0;
            if (wr_valid) begin
                if (wr_wait == 0) begin
                    o.wdata = wr_data;
                    o.mask  = wr_mask;
                end else if (wr_data !== o.wdata || wr_mask !== o.mask) begin
                    o.wr_stable = 1'b0;
                end
                if (wr_wait >= wr_stall) begin
                    wr_ready = 1'b1;
                    o.n_wr++;
                end
                wr_wait++;
            end
            resp_ready = 1'b0;
            if (resp_valid) begin
                if (resp_wait == 0) begin
                    o.rdata = resp_data;
                    o.err   = resp_err;
                    o.tag   = resp_tag;
                    o.lat   = cyc - acc_cyc;
                end else if (resp_data !== o.rdata || resp_err !== o.err || resp_tag !== o.tag) begin
                    o.resp_stable = 1'b0;
                end
                if (resp_wait >= resp_stall) begin
                    resp_ready = 1'b1;
                    o.n_resp++;
                    o.done = 1'b1;
                end
                resp_wait++;
            end
            if (req_valid && req_ready && !accepted) begin
                accepted = 1;
                acc_cyc  = cyc;
            end
            @(negedge clk);
        end
        req_valid = 1'b0; wr_ready = 1'b0; resp_ready = 1'b0; rd_resp_valid = 1'b0;
        o.ready_after = req_ready;
        // Watch a few idle cycles for any duplicate activity.
        for (int k = 0; k < 3; k++) begin
            if (rd_req_valid) o.n_rd++;
            if (wr_valid) o.n_wr++;
            if (resp_valid) o.n_resp++;
            @(negedge clk);
        end
        $display("txn op=%0d w=%0b off=%0d rs2=%h old=%h -> wr=%h mask=%h resp=%h err=%0b tag=%0d lat=%0d",
                 op, w, off, rs2, old, o.wdata, o.mask, o.rdata, o.err, o.tag, o.lat);
    endtask

    task automatic check_obs(input string tn, input obs_t o, input logic [63:0] exp_wd, input logic [7:0] exp_mk,
                             input logic [63:0] exp_rd, input logic exp_err, input logic [5:0] exp_tag,
                             input int exp_lat);
        chk({tn, ".done"}, o.done, 1'b1);
        chk({tn, ".err"}, o.err, exp_err);
        chk({tn, ".resp_data"}, o.rdata, exp_rd);
        chk({tn, ".tag"}, o.tag, exp_tag);
        chk({tn, ".n_resp"}, o.n_resp, 1);
        chk({tn, ".n_rd"}, o.n_rd, exp_err ? 0 : 1);
        chk({tn, ".n_wr"}, o.n_wr, exp_err ? 0 : 1);
        if (!exp_err) begin
            chk({tn, ".wr_data"}, o.wdata, exp_wd);
            chk({tn, ".wr_mask"}, o.mask, exp_mk);
        end
        if (exp_lat >= 0) chk({tn, ".latency"}, o.lat, exp_lat);
        chk({tn, ".ready_after"}, o.ready_after, 1'b1);
    endtask

    vec_t tbl [14];

    initial begin
        obs_t        o;
        logic [63:0] e_wd, e_rd, r_old, r_rs2;
        logic [7:0]  e_mk;
        logic        e_err, r_w;
        logic [3:0]  r_op;
        logic [2:0]  r_off;
        logic [5:0]  r_tag;
        int          ws, rs, bad;

        tbl[0]  = '{AMO_ADD,  1'b0, 3'd0, 64'h3, 64'h5, 6'd1, 64'h8, 8'hFF, 64'h5, 1'b0};
        tbl[1]  = '{AMO_MAX,  1'b1, 3'd4, 64'h1, 64'h8000_0000_0000_0001, 6'd2,
                    64'h0000_0001_0000_0001, 8'hF0, 64'hFFFF_FFFF_8000_0000, 1'b0};
        tbl[2]  = '{AMO_MINU, 1'b1, 3'd0, 64'h1, 64'h0000_0000_FFFF_FFFF, 6'd3,
                    64'h0000_0001_0000_0001, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[3]  = '{AMO_OR,   1'b0, 3'd4, 64'hFF, 64'h1234, 6'h2A, 64'h0, 8'h00, 64'h0, 1'b1};
        tbl[4]  = '{AMO_SWAP, 1'b0, 3'd0, 64'hAABB_CCDD_EEFF_0011, 64'h1122_3344_5566_7788, 6'd4,
                    64'hAABB_CCDD_EEFF_0011, 8'hFF, 64'h1122_3344_5566_7788, 1'b0};
        tbl[5]  = '{AMO_MIN,  1'b0, 3'd0, 64'h5, 64'hFFFF_FFFF_FFFF_FFFF, 6'd5,
                    64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[6]  = '{AMO_MAXU, 1'b0, 3'd0, 64'h5, 64'hFFFF_FFFF_FFFF_FFFF, 6'd6,
                    64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[7]  = '{AMO_XOR,  1'b1, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0F0F_0F0F_0000_0000, 6'd7,
                    64'hF0F0_F0F0_F0F0_F0F0, 8'hF0, 64'h0000_0000_0F0F_0F0F, 1'b0};
        tbl[8]  = '{AMO_ADD,  1'b1, 3'd0, 64'h1234_5678_0000_0001, 64'h0000_0000_7FFF_FFFF, 6'd8,
                    64'h8000_0000_8000_0000, 8'h0F, 64'h0000_0000_7FFF_FFFF, 1'b0};
        tbl[9]  = '{AMO_AND,  1'b1, 3'd2, 64'h1, 64'h1, 6'd9, 64'h0, 8'h00, 64'h0, 1'b1};
        tbl[10] = '{AMO_MIN,  1'b1, 3'd4, 64'h1234_5678, 64'h1234_5678_9ABC_DEF0, 6'd10,
                    64'h1234_5678_1234_5678, 8'hF0, 64'h0000_0000_1234_5678, 1'b0};
        tbl[11] = '{AMO_AND,  1'b0, 3'd0, 64'hFF00_FF00_FF00_FF00, 64'hF0F0_F0F0_F0F0_F0F0, 6'd11,
                    64'hF000_F000_F000_F000, 8'hFF, 64'hF0F0_F0F0_F0F0_F0F0, 1'b0};
        tbl[12] = '{AMO_MAX,  1'b0, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 6'd12,
                    64'h7FFF_FFFF_FFFF_FFFF, 8'hFF, 64'h8000_0000_0000_0000, 1'b0};
        tbl[13] = '{AMO_MINU, 1'b1, 3'd4, 64'h2, 64'hFFFF_FFFF_0000_0000, 6'd13,
                    64'h0000_0002_0000_0002, 8'hF0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst.req_ready", req_ready, 1'b1);
        chk("rst.rd_req_valid", rd_req_valid, 1'b0);
        chk("rst.wr_valid", wr_valid, 1'b0);
        chk("rst.resp_valid", resp_valid, 1'b0);
        chk("rst.resp_err", resp_err, 1'b0);
        chk("rst.wr_mask", wr_mask, 8'h00);
        chk("rst.wr_data", wr_data, 64'h0);
        chk("rst.resp_data", resp_data, 64'h0);
        chk("rst.resp_tag", resp_tag, 6'h0);

        // Directed table, all readies high: latency 5 (1 for misaligned)
        foreach (tbl[i]) begin
            run_amo(tbl[i].op, tbl[i].w, tbl[i].off, tbl[i].rs2, tbl[i].old, tbl[i].tag, 0, 0, o);
            check_obs($sformatf("v%0d", i), o, tbl[i].exp_wdata, tbl[i].exp_mask, tbl[i].exp_resp,
                      tbl[i].exp_err, tbl[i].tag, tbl[i].exp_err ? 1 : 5);
        end

        // Backpressure: write held 3 cycles, response held 2 cycles
        run_amo(AMO_SWAP, 1'b0, 3'd0, 64'hCAFE_BABE_DEAD_BEEF, 64'h1111_2222_3333_4444, 6'd33, 3, 2, o);
        check_obs("bp", o, 64'hCAFE_BABE_DEAD_BEEF, 8'hFF, 64'h1111_2222_3333_4444, 1'b0, 6'd33, 8);
        chk("bp.wr_stable", o.wr_stable, 1'b1);
        chk("bp.resp_stable", o.resp_stable, 1'b1);

        // Reset in RD_WAIT followed by a stray read response
        @(negedge clk);
        req_valid = 1'b1; req_op = AMO_ADD; req_w = 1'b0; req_off = 3'd0; req_rs2 = 64'h7; req_tag = 6'd21;
        rd_req_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid.rd_req", rd_req_valid, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rd_resp_valid = 1'b1; rd_resp_data = 64'h1234;
        @(negedge clk);
        rd_resp_valid = 1'b0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (wr_valid || resp_valid || rd_req_valid || !req_ready) bad++;
            @(negedge clk);
        end
        chk("rstmid.no_activity", bad, 0);
        chk("rstmid.wr_mask", wr_mask, 8'h00);
        chk("rstmid.resp_data", resp_data, 64'h0);
        chk("rstmid.resp_err", resp_err, 1'b0);
        chk("rstmid.resp_tag", resp_tag, 6'h0);
        run_amo(tbl[0].op, tbl[0].w, tbl[0].off, tbl[0].rs2, tbl[0].old, tbl[0].tag, 0, 0, o);
        check_obs("rstmid.next", o, tbl[0].exp_wdata, tbl[0].exp_mask, tbl[0].exp_resp, 1'b0, tbl[0].tag, 5);

        // Randomized AMOs against the reference model
        for (int n = 0; n < 150; n++) begin
            r_op  = 4'($urandom_range(0, 8));
            r_w   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) r_off = 3'($urandom_range(0, 7));
            else                          r_off = r_w ? {1'($urandom_range(0, 1)), 2'b00} : 3'd0;
            r_old = {$urandom, $urandom};
            r_rs2 = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) r_rs2 = r_w ? {32'h0, (r_off[2] ? r_old[63:32] : r_old[31:0])} : r_old;
            r_tag = 6'($urandom_range(0, 63));
            ws = $urandom_range(0, 2);
            rs = $urandom_range(0, 2);
            ref_amo(r_op, r_w, r_off, r_rs2, r_old, e_wd, e_mk, e_rd, e_err);
            run_amo(r_op, r_w, r_off, r_rs2, r_old, r_tag, ws, rs, o);
            check_obs($sformatf("rnd%0d", n), o, e_wd, e_mk, e_rd, e_err, r_tag, e_err ? 1 : 5 + ws);
            chk($sformatf("rnd%0d.stable", n), {o.wr_stable, o.resp_stable}, 2'b11);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
